bram_port_arbiter: RTL and testbench

//  Shares the single port of the 64x8 character block RAM between two requesters:
//  the keyboard write path (ASCII char + write address) and a read-back client
//  (display/serial dump). One access issued per cycle max; round-robin on conflict.

---
 rtl/bram_arb_pkg.sv | 23 ++
 rtl/rd_valid_pipe.sv | 30 +++
 rtl/bram_port_arbiter.sv | 115 +++++++++++
 tb/tb_bram_port_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_arb_pkg.sv
// Shared definitions for the character-RAM port arbiter: FSM states,
// requester identities and the default RAM geometry.
package bram_arb_pkg;

    localparam int unsigned DEF_AW = 6;
    localparam int unsigned DEF_DW = 8;

    typedef enum logic [1:0] {
        ARB      = 2'd0,
        ISSUE_WR = 2'd1,
        ISSUE_RD = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_WR = 1'b0,
        REQ_RD = 1'b1
    } req_id_e;

    function automatic arb_state_e issue_state(input req_id_e who);
        return (who == REQ_WR) ? ISSUE_WR : ISSUE_RD;
    endfunction

endpackage

// File: rtl/rd_valid_pipe.sv
// Delays the read grant by RD_LAT cycles to mark when read data is returned.
// o_tap is the stage feeding the last flop: rd_data is loaded on that edge.
module rd_valid_pipe #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_gnt,
    output logic o_tap,
    output logic o_valid
);

    logic [RD_LAT-1:0] r_stage;
    logic [RD_LAT:0]   w_chain;

    // Bit 0 is the live grant, bit k is the grant delayed by k cycles.
    assign w_chain = {r_stage, i_gnt};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage <= '0;
        end else begin
            r_stage <= w_chain[RD_LAT-1:0];
        end
    end

    assign o_tap   = w_chain[RD_LAT-1];
    assign o_valid = w_chain[RD_LAT];

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing the single character-RAM port between the
// keyboard write path and a read-back client. All outputs are registered.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int unsigned AW     = DEF_AW,
    parameter int unsigned DW     = DEF_DW,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_gnt,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_gnt,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    arb_state_e    r_state;
    arb_state_e    w_next_state;
    req_id_e       r_last_served;
    req_id_e       w_winner;
    logic          w_wr_elig;
    logic          w_rd_elig;
    logic          w_tap;
    logic          r_wr_gnt;
    logic          r_rd_gnt;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_din;
    logic [DW-1:0] r_rd_data;

    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        w_wr_elig    = wr_req;
        w_rd_elig    = rd_req;
        w_winner     = REQ_WR;
        w_next_state = ARB;
        // The requester granted this cycle still shows its old request.
        if (r_state == ISSUE_WR) w_wr_elig = 1'b0;
        if (r_state == ISSUE_RD) w_rd_elig = 1'b0;
        if (w_wr_elig && w_rd_elig) begin
            if (r_last_served == REQ_WR) w_winner = REQ_RD;
            w_next_state = issue_state(w_winner);
        end else if (w_wr_elig) begin
            w_next_state = ISSUE_WR;
        end else if (w_rd_elig) begin
            w_next_state = ISSUE_RD;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: the RAM-side address/data registers are reset as well, because the
    // reset values are observable outputs; the RAM array itself is never reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_gnt      <= 1'b0;
            r_rd_gnt      <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_din     <= '0;
            r_rd_data     <= '0;
            r_last_served <= REQ_RD;
        end else begin
            r_wr_gnt <= (w_next_state == ISSUE_WR);
            r_rd_gnt <= (w_next_state == ISSUE_RD);
            r_mem_we <= (w_next_state == ISSUE_WR);
            if (w_next_state == ISSUE_WR) begin
                r_mem_addr    <= wr_addr;
                r_mem_din     <= wr_data;
                r_last_served <= REQ_WR;
            end else if (w_next_state == ISSUE_RD) begin
                r_mem_addr    <= rd_addr;
                r_last_served <= REQ_RD;
            end
            if (w_tap) r_rd_data <= mem_dout;
        end
    end

    rd_valid_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_valid_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_gnt   (r_rd_gnt),
        .o_tap   (w_tap),
        .o_valid (rd_valid)
    );

    assign wr_gnt   = r_wr_gnt;
    assign rd_gnt   = r_rd_gnt;
    assign mem_we   = r_mem_we;
    assign mem_addr = r_mem_addr;
    assign mem_din  = r_mem_din;
    assign rd_data  = r_rd_data;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter with RD_LAT=2 against a synchronous RAM model
// (one output register) and a rule-level reference model of the arbitration.
module tb_bram_port_arbiter;

  localparam int AW     = 6;
  localparam int DW     = 8;
  localparam int RD_LAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_gnt;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_gnt;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  always #5 clk = ~clk;

  bram_port_arbiter #(
    .AW     (AW),
    .DW     (DW),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_req   (wr_req),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_gnt   (wr_gnt),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_gnt   (rd_gnt),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout)
  );

  // RAM with RD_LAT-1 = 1 output register stage.
  logic [DW-1:0] ram [64];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    mem_dout <= ram[mem_addr];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input logic ok, input string msg);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL %s", msg);
    end
  endtask

  // Reference model: grants decided from the access rules, data from a shadow memory.
  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } pend_t;

  pend_t         pend[$];
  logic [DW-1:0] ref_mem [64];
  int            cyc_n = 0;
  logic          m_wr_gnt, m_rd_gnt, m_rd_valid, m_mem_we, m_last_rd;
  logic [AW-1:0] m_mem_addr;
  logic [DW-1:0] m_mem_din, m_rd_data;

  task automatic model_step();
    logic wr_ok, rd_ok, g_wr, g_rd;
    cyc_n++;
    if (rst) begin
      m_wr_gnt = 0; m_rd_gnt = 0; m_rd_valid = 0; m_mem_we = 0;
      m_mem_addr = '0; m_mem_din = '0; m_rd_data = '0; m_last_rd = 1;
      pend.delete();
    end else begin
      wr_ok = wr_req && !m_wr_gnt;
      rd_ok = rd_req && !m_rd_gnt;
      g_wr  = (wr_ok && rd_ok) ? m_last_rd : wr_ok;
      g_rd  = rd_ok && !g_wr;
      m_rd_valid = 0;
      if (pend.size() > 0 && pend[0].due == cyc_n) begin
        m_rd_valid = 1;
        m_rd_data  = pend[0].data;
        void'(pend.pop_front());
      end
      m_mem_we = g_wr;
      if (g_wr) begin
        m_mem_addr = wr_addr;
        m_mem_din  = wr_data;
        ref_mem[wr_addr] = wr_data;
        m_last_rd = 0;
      end
      if (g_rd) begin
        m_mem_addr = rd_addr;
        pend.push_back('{cyc_n + RD_LAT, ref_mem[rd_addr]});
        m_last_rd = 1;
      end
      m_wr_gnt = g_wr;
      m_rd_gnt = g_rd;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1; wr_req = 0; rd_req = 0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    tick(); tick();
    check({wr_gnt, rd_gnt, rd_valid, mem_we} === 4'b0,
          $sformatf("reset_flags: got %b expected 0000", {wr_gnt, rd_gnt, rd_valid, mem_we}));
    check({mem_addr, mem_din, rd_data} === '0,
          $sformatf("reset_data: got addr=%h din=%h rd_data=%h expected all 0", mem_addr, mem_din, rd_data));
    wr_req = 1; rd_req = 1;
    tick();
    check({wr_gnt, rd_gnt} === 2'b00,
          $sformatf("reset_holds_gnt: got %b expected 00", {wr_gnt, rd_gnt}));
    wr_req = 0; rd_req = 0; rst = 0;
    tick();
    check({wr_gnt, rd_gnt, mem_we} === 3'b000,
          $sformatf("idle_after_reset: got %b expected 000", {wr_gnt, rd_gnt, mem_we}));
  endtask

  task automatic test_fill();
    for (int a = 0; a < 64; a++) begin
      int n;
      wr_req = 1; wr_addr = AW'(a); wr_data = DW'($urandom);
      n = 0;
      do begin
        tick();
        n++;
      end while (wr_gnt !== 1'b1 && n < 4);
      check(wr_gnt === 1'b1 && mem_addr === AW'(a) && mem_din === wr_data && mem_we === 1'b1,
            $sformatf("fill_write: addr %0d got gnt=%b we=%b addr=%h din=%h expected gnt=1 we=1 addr=%h din=%h",
                      a, wr_gnt, mem_we, mem_addr, mem_din, AW'(a), wr_data));
    end
    wr_req = 0;
    tick();
  endtask

  task automatic test_single_write();
    wr_req = 1; wr_addr = 6'd5; wr_data = 8'h41;
    tick();
    check({wr_gnt, rd_gnt, mem_we} === 3'b101,
          $sformatf("single_write_gnt: got gnt/rgnt/we=%b expected 101", {wr_gnt, rd_gnt, mem_we}));
    check(mem_addr === 6'd5 && mem_din === 8'h41,
          $sformatf("single_write_bus: got addr=%h din=%h expected addr=05 din=41", mem_addr, mem_din));
    wr_req = 0;
    tick();
    check({wr_gnt, mem_we} === 2'b00 && mem_addr === 6'd5,
          $sformatf("single_write_release: got gnt=%b we=%b addr=%h expected 0 0 05", wr_gnt, mem_we, mem_addr));
  endtask

  task automatic test_read_back();
    rd_req = 1; rd_addr = 6'd5;
    tick();
    check({rd_gnt, wr_gnt, mem_we} === 3'b100 && mem_addr === 6'd5,
          $sformatf("read_gnt: got rgnt/wgnt/we=%b addr=%h expected 100 addr=05", {rd_gnt, wr_gnt, mem_we}, mem_addr));
    rd_req = 0;
    tick();
    check(rd_valid === 1'b0,
          $sformatf("read_early_valid: got %b expected 0", rd_valid));
    tick();
    check(rd_valid === 1'b1 && rd_data === 8'h41,
          $sformatf("read_data: got valid=%b data=%h expected valid=1 data=41", rd_valid, rd_data));
    tick();
    check(rd_valid === 1'b0 && rd_data === 8'h41,
          $sformatf("read_hold: got valid=%b data=%h expected valid=0 data=41", rd_valid, rd_data));
  endtask

  task automatic test_conflict();
    // Last served was the read, so the write wins and the read follows.
    wr_req = 1; wr_addr = 6'd9; wr_data = 8'h5a;
    rd_req = 1; rd_addr = 6'd9;
    tick();
    check({wr_gnt, rd_gnt} === 2'b10,
          $sformatf("conflict1_first: got wgnt/rgnt=%b expected 10", {wr_gnt, rd_gnt}));
    wr_req = 0;
    tick();
    check({wr_gnt, rd_gnt} === 2'b01 && mem_addr === 6'd9,
          $sformatf("conflict1_second: got wgnt/rgnt=%b addr=%h expected 01 addr=09", {wr_gnt, rd_gnt}, mem_addr));
    rd_req = 0;
    tick(); tick();
    check(rd_valid === 1'b1 && rd_data === 8'h5a,
          $sformatf("conflict1_data: got valid=%b data=%h expected valid=1 data=5a", rd_valid, rd_data));
    // A lone write makes the next conflict go to the read.
    wr_req = 1; wr_addr = 6'd12; wr_data = 8'h33;
    tick();
    wr_req = 0;
    tick();
    wr_req = 1; wr_addr = 6'd13; wr_data = 8'h44;
    rd_req = 1; rd_addr = 6'd12;
    tick();
    check({wr_gnt, rd_gnt} === 2'b01,
          $sformatf("conflict2_first: got wgnt/rgnt=%b expected 01", {wr_gnt, rd_gnt}));
    rd_req = 0;
    tick();
    check({wr_gnt, rd_gnt} === 2'b10 && mem_addr === 6'd13 && mem_din === 8'h44,
          $sformatf("conflict2_second: got wgnt/rgnt=%b addr=%h din=%h expected 10 addr=0d din=44",
                    {wr_gnt, rd_gnt}, mem_addr, mem_din));
    wr_req = 0;
    tick();
    check(rd_valid === 1'b1 && rd_data === 8'h33,
          $sformatf("conflict2_data: got valid=%b data=%h expected valid=1 data=33", rd_valid, rd_data));
  endtask

  task automatic test_back_to_back();
    int   wr_cnt = 0;
    int   rd_cnt = 0;
    logic prev_wr = 1'b0;
    wr_req = 1; wr_addr = 6'd20; wr_data = DW'($urandom);
    rd_req = 1; rd_addr = 6'd21;
    for (int i = 0; i < 20; i++) begin
      tick();
      check((wr_gnt ^ rd_gnt) === 1'b1 && !(i > 0 && wr_gnt === prev_wr),
            $sformatf("b2b_alternate: cycle %0d got wgnt/rgnt=%b prev_wgnt=%b expected one grant, alternating",
                      i, {wr_gnt, rd_gnt}, prev_wr));
      prev_wr = wr_gnt;
      if (wr_gnt === 1'b1) wr_cnt++;
      if (rd_gnt === 1'b1) rd_cnt++;
    end
    check(wr_cnt == 10 && rd_cnt == 10,
          $sformatf("b2b_counts: got wr=%0d rd=%0d expected 10 each", wr_cnt, rd_cnt));
    wr_req = 0; rd_req = 0;
    repeat (4) tick();
  endtask

  task automatic test_reset_mid_read();
    rd_req = 1; rd_addr = 6'd3;
    tick();
    check(rd_gnt === 1'b1,
          $sformatf("midrst_gnt: got %b expected 1", rd_gnt));
    rst = 1; rd_req = 0; wr_req = 1; wr_addr = 6'd7; wr_data = 8'h99;
    tick();
    check({wr_gnt, rd_gnt, rd_valid, mem_we, mem_addr, mem_din, rd_data} === '0,
          $sformatf("midrst_outputs: got gnt=%b%b valid=%b we=%b addr=%h din=%h data=%h expected all 0",
                    wr_gnt, rd_gnt, rd_valid, mem_we, mem_addr, mem_din, rd_data));
    rst = 0; wr_req = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check(rd_valid === 1'b0 && rd_data === 8'h00,
            $sformatf("midrst_dropped: cycle %0d got valid=%b data=%h expected 0 00", i, rd_valid, rd_data));
    end
  endtask

  task automatic test_wrap();
    wr_req = 1; wr_addr = 6'd63; wr_data = 8'h7e;
    tick();
    check(wr_gnt === 1'b1 && mem_addr === 6'd63,
          $sformatf("wrap_top: got gnt=%b addr=%h expected 1 3f", wr_gnt, mem_addr));
    wr_addr = 6'd0; wr_data = 8'h30;
    tick();
    check(wr_gnt === 1'b0 && mem_we === 1'b0 && mem_addr === 6'd63,
          $sformatf("wrap_gap: got gnt=%b we=%b addr=%h expected 0 0 3f", wr_gnt, mem_we, mem_addr));
    tick();
    check(wr_gnt === 1'b1 && mem_addr === 6'd0 && mem_din === 8'h30,
          $sformatf("wrap_zero: got gnt=%b addr=%h din=%h expected 1 00 30", wr_gnt, mem_addr, mem_din));
    for (int i = 0; i < 6; i++) begin
      logic exp_gnt;
      exp_gnt = (i % 2 == 1);
      tick();
      check(wr_gnt === exp_gnt,
            $sformatf("wrap_every_other: cycle %0d got %b expected %b", i, wr_gnt, exp_gnt));
    end
    wr_req = 0;
    repeat (2) tick();
  endtask

  task automatic test_random();
    int wr_wait = 0;
    int rd_wait = 0;
    wr_req = 0; rd_req = 0; rst = 0;
    for (int i = 0; i < 500; i++) begin
      tick();
      check({wr_gnt, rd_gnt, rd_valid, mem_we, mem_addr, mem_din, rd_data} ===
            {m_wr_gnt, m_rd_gnt, m_rd_valid, m_mem_we, m_mem_addr, m_mem_din, m_rd_data},
            $sformatf("random_cycle %0d: got gnt=%b%b v=%b we=%b a=%h d=%h rd=%h expected gnt=%b%b v=%b we=%b a=%h d=%h rd=%h",
                      i, wr_gnt, rd_gnt, rd_valid, mem_we, mem_addr, mem_din, rd_data,
                      m_wr_gnt, m_rd_gnt, m_rd_valid, m_mem_we, m_mem_addr, m_mem_din, m_rd_data));
      if (rst) begin
        wr_wait = 0;
        rd_wait = 0;
      end else begin
        if (wr_gnt === 1'b1) begin
          check(wr_wait + 1 <= 3,
                $sformatf("random_wr_latency: got %0d cycles expected <= 3", wr_wait + 1));
          wr_wait = 0;
          wr_req  = ($urandom % 2 == 0);
          wr_addr = AW'($urandom); wr_data = DW'($urandom);
        end else if (wr_req) begin
          if ($urandom % 16 == 0) begin wr_req = 0; wr_wait = 0; end
          else wr_wait++;
        end else if ($urandom % 3 == 0) begin
          wr_req = 1; wr_wait = 0;
          wr_addr = AW'($urandom); wr_data = DW'($urandom);
        end
        if (rd_gnt === 1'b1) begin
          check(rd_wait + 1 <= 3,
                $sformatf("random_rd_latency: got %0d cycles expected <= 3", rd_wait + 1));
          rd_wait = 0;
          rd_req  = ($urandom % 2 == 0);
          rd_addr = AW'($urandom);
        end else if (rd_req) begin
          if ($urandom % 16 == 0) begin rd_req = 0; rd_wait = 0; end
          else rd_wait++;
        end else if ($urandom % 3 == 0) begin
          rd_req = 1; rd_wait = 0;
          rd_addr = AW'($urandom);
        end
      end
      rst = ($urandom % 64 == 0);
    end
    rst = 0; wr_req = 0; rd_req = 0;
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_single_write();
    test_read_back();
    test_conflict();
    test_back_to_back();
    test_reset_mid_read();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
